// File: rtl/imem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imem_arbiter_pkg
// Shared processor constants for the instruction-memory arbiter:
//   - default instruction-memory word-index width and starvation limit
//   - one-hot encoding of the read-owner state machine
//   - helper that classifies a debug byte address as unusable
// -----------------------------------------------------------------------------
package imem_arbiter_pkg;

    // 512-word instruction memory by default.
    localparam int unsigned ADDR_W_DEFAULT     = 9;
    // Fetch grants allowed back-to-back while a debug read is waiting.
    localparam int unsigned STARVE_MAX_DEFAULT = 8;

    // Owner of the read currently in flight (one-hot).
    typedef enum logic [2:0] {
        OWN_IDLE     = 3'b001,
        OWN_RD_FETCH = 3'b010,
        OWN_RD_DBG   = 3'b100
    } owner_e;

    // A debug address is unusable when it is not word aligned or when it
    // points beyond the word range covered by addr_w index bits.
    function automatic logic dbg_addr_bad(input logic [31:0] addr,
                                          input int unsigned addr_w);
        logic [31:0] upper;
        upper = addr >> (addr_w + 32'd2);
        return (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_if
// Bundles the fetch port, the debug/readback port and the synchronous
// instruction-memory port seen by the arbiter.
//   slave  : arbiter side (takes requests and read data, drives grants,
//            results and the memory command)
//   master : environment side (requesters plus memory)
// -----------------------------------------------------------------------------
interface imem_arbiter_if
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);

    // Fetch port
    logic              Fetch_Req;
    logic [31:0]       Fetch_Addr;
    logic              Fetch_Gnt;
    logic              Fetch_Valid;
    logic [31:0]       Fetch_Data;

    // Debug / readback port
    logic              Dbg_Req;
    logic [31:0]       Dbg_Addr;
    logic              Dbg_Gnt;
    logic              Dbg_Valid;
    logic [31:0]       Dbg_Data;
    logic              Dbg_Err;

    // Instruction memory port
    logic              Mem_En;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_Rdata;

    modport slave (
        input  Fetch_Req, Fetch_Addr, Dbg_Req, Dbg_Addr, Mem_Rdata,
        output Fetch_Gnt, Fetch_Valid, Fetch_Data,
        output Dbg_Gnt, Dbg_Valid, Dbg_Data, Dbg_Err,
        output Mem_En, Mem_Addr
    );

    modport master (
        output Fetch_Req, Fetch_Addr, Dbg_Req, Dbg_Addr, Mem_Rdata,
        input  Fetch_Gnt, Fetch_Valid, Fetch_Data,
        input  Dbg_Gnt, Dbg_Valid, Dbg_Data, Dbg_Err,
        input  Mem_En, Mem_Addr
    );

endinterface

// File: rtl/imem_starve_cnt.sv
// -----------------------------------------------------------------------------
// imem_starve_cnt
// Counts fetch grants issued while a debug request is pending and flags when
// the debug requester must win the next arbitration.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   dbg_req     : debug requester is asking for a read
//   fetch_gnt   : fetch was granted this cycle
//   dbg_gnt     : debug was granted this cycle
//   starved     : count has reached STARVE_MAX (debug must be served)
// -----------------------------------------------------------------------------
module imem_starve_cnt
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dbg_req,
    input  logic fetch_gnt,
    input  logic dbg_gnt,
    output logic starved
);

    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Starvation count: cleared whenever debug is idle or served, saturating
    // increment on every fetch grant that overtook a waiting debug request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            count_r <= '0;
        end else if (fetch_gnt && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign starved = (count_r == CNT_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Shares a single-port synchronous instruction memory between the fetch
// stage (priority) and a debug/readback port (anti-starvation guaranteed).
// One read per cycle, one-cycle latency, results routed back to whoever
// owned the read.
// Ports:
//   Clk  : clock, all state changes on rising edge
//   Rst  : asynchronous active-low reset
//   bus  : imem_arbiter_if.slave -- fetch port, debug port, memory port
// -----------------------------------------------------------------------------
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic           Clk,
    input  logic           Rst,
    imem_arbiter_if.slave  bus
);

    logic              starved_s;
    logic              fetch_gnt_s;
    logic              dbg_gnt_s;
    logic              dbg_bad_s;
    logic              mem_en_s;
    logic [ADDR_W-1:0] mem_addr_s;
    owner_e            next_owner_s;

    owner_e            owner_r;
    logic [31:0]       fetch_data_r;
    logic [31:0]       dbg_data_r;
    logic              dbg_err_r;

    logic              fetch_valid_s;
    logic              dbg_valid_s;

    imem_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk       (Clk),
        .rst_n     (Rst),
        .dbg_req   (bus.Dbg_Req),
        .fetch_gnt (fetch_gnt_s),
        .dbg_gnt   (dbg_gnt_s),
        .starved   (starved_s)
    );

    assign dbg_bad_s = dbg_addr_bad(bus.Dbg_Addr, ADDR_W);

    // Grant selection: fetch first unless debug has waited too long; nothing
    // is granted while reset is held so no memory cycle can start.
    always_comb begin
        fetch_gnt_s = 1'b0;
        dbg_gnt_s   = 1'b0;
        if (Rst) begin
            if (bus.Fetch_Req && !(bus.Dbg_Req && starved_s)) begin
                fetch_gnt_s = 1'b1;
            end else if (bus.Dbg_Req) begin
                dbg_gnt_s = 1'b1;
            end else begin
                fetch_gnt_s = 1'b0;
                dbg_gnt_s   = 1'b0;
            end
        end else begin
            fetch_gnt_s = 1'b0;
            dbg_gnt_s   = 1'b0;
        end
    end

    // Memory command and next owner. A rejected debug address is still
    // granted (it gets an error response) but never reaches the memory,
    // so its address is presented as 0 like an idle cycle.
    always_comb begin
        mem_en_s     = 1'b0;
        mem_addr_s   = '0;
        next_owner_s = OWN_IDLE;
        if (fetch_gnt_s) begin
            mem_en_s     = 1'b1;
            mem_addr_s   = bus.Fetch_Addr[ADDR_W+1:2];
            next_owner_s = OWN_RD_FETCH;
        end else if (dbg_gnt_s) begin
            next_owner_s = OWN_RD_DBG;
            if (dbg_bad_s) begin
                mem_en_s   = 1'b0;
                mem_addr_s = '0;
            end else begin
                mem_en_s   = 1'b1;
                mem_addr_s = bus.Dbg_Addr[ADDR_W+1:2];
            end
        end else begin
            mem_en_s     = 1'b0;
            mem_addr_s   = '0;
            next_owner_s = OWN_IDLE;
        end
    end

    // Owner FSM plus the held copies of the last results; the error flag is
    // latched at grant time so it is already stable during the Valid cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            owner_r      <= OWN_IDLE;
            fetch_data_r <= 32'd0;
            dbg_data_r   <= 32'd0;
            dbg_err_r    <= 1'b0;
        end else begin
            owner_r <= next_owner_s;
            case (owner_r)
                OWN_RD_FETCH: begin
                    fetch_data_r <= bus.Mem_Rdata;
                    dbg_data_r   <= dbg_data_r;
                end
                OWN_RD_DBG: begin
                    fetch_data_r <= fetch_data_r;
                    dbg_data_r   <= dbg_err_r ? 32'd0 : bus.Mem_Rdata;
                end
                default: begin
                    fetch_data_r <= fetch_data_r;
                    dbg_data_r   <= dbg_data_r;
                end
            endcase
            if (dbg_gnt_s) begin
                dbg_err_r <= dbg_bad_s;
            end else begin
                dbg_err_r <= dbg_err_r;
            end
        end
    end

    // Valid comes straight from the owner flops. Memory data only arrives
    // during the Valid cycle, so the data outputs pass it through then and
    // show the held copy otherwise.
    assign fetch_valid_s   = (owner_r == OWN_RD_FETCH);
    assign dbg_valid_s     = (owner_r == OWN_RD_DBG);

    assign bus.Fetch_Gnt   = fetch_gnt_s;
    assign bus.Dbg_Gnt     = dbg_gnt_s;
    assign bus.Mem_En      = mem_en_s;
    assign bus.Mem_Addr    = mem_addr_s;
    assign bus.Fetch_Valid = fetch_valid_s;
    assign bus.Fetch_Data  = fetch_valid_s ? bus.Mem_Rdata : fetch_data_r;
    assign bus.Dbg_Valid   = dbg_valid_s;
    assign bus.Dbg_Data    = dbg_valid_s ? (dbg_err_r ? 32'd0 : bus.Mem_Rdata)
                                         : dbg_data_r;
    assign bus.Dbg_Err     = dbg_err_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
// Directed, table-driven bench for imem_arbiter with a synchronous memory
// model whose word at index a reads as 0x8C010000 + a.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int unsigned AW = 9;

    logic Clk;
    logic Rst;

    imem_arbiter_if #(.ADDR_W(AW)) bus ();

    imem_arbiter #(
        .ADDR_W     (AW),
        .STARVE_MAX (8)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h8C01_0000 + {23'd0, a};
    endfunction

    // Synchronous memory: data one cycle after enable, junk when not enabled.
    always @(posedge Clk) begin
        if (bus.Mem_En) bus.Mem_Rdata <= mem_word(bus.Mem_Addr);
        else            bus.Mem_Rdata <= 32'hDEAD_BEEF;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        dr;
        logic [31:0] da;
        logic        efg;
        logic        edg;
        logic        een;
        logic [31:0] eaddr;
        logic        efv;
        logic [31:0] efd;
        logic        edv;
        logic [31:0] edd;
        logic        ede;
    } vec_t;

    vec_t vecs [12];

    task automatic drive(input logic fr, input logic [31:0] fa,
                         input logic dr, input logic [31:0] da);
        bus.Fetch_Req  = fr;
        bus.Fetch_Addr = fa;
        bus.Dbg_Req    = dr;
        bus.Dbg_Addr   = da;
    endtask

    initial begin
        // Each vector is applied for one cycle; valid/data columns reflect
        // the grant of the previous vector.
        //              fr    fa            dr    da            fg    dg    en    addr    fv    fd             dv    dd             de
        vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'd4,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0020, 1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'h8C01_0004, 1'b0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0804, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'd1,  1'b0, 32'h8C01_0004, 1'b1, 32'h8C01_0008, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 32'h8C01_0001, 1'b0, 32'h8C01_0008, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0800, 1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 32'h8C01_0001, 1'b1, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'h8C01_0001, 1'b1, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'h8C01_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0040, 1'b1, 32'h0000_0044, 1'b1, 1'b0, 1'b1, 32'd16, 1'b0, 32'h8C01_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 32'd17, 1'b1, 32'h8C01_0010, 1'b0, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 32'h8C01_0010, 1'b1, 32'h8C01_0011, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'h8C01_0000, 1'b0, 32'h8C01_0011, 1'b0};

        // Reset state with both requests raised: nothing may be granted.
        Rst = 1'b0;
        drive(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0020);
        #1;
        chk("rst fetch_gnt",   bus.Fetch_Gnt,   32'd0);
        chk("rst dbg_gnt",     bus.Dbg_Gnt,     32'd0);
        chk("rst mem_en",      bus.Mem_En,      32'd0);
        chk("rst mem_addr",    bus.Mem_Addr,    32'd0);
        chk("rst fetch_valid", bus.Fetch_Valid, 32'd0);
        chk("rst fetch_data",  bus.Fetch_Data,  32'd0);
        chk("rst dbg_valid",   bus.Dbg_Valid,   32'd0);
        chk("rst dbg_data",    bus.Dbg_Data,    32'd0);
        chk("rst dbg_err",     bus.Dbg_Err,     32'd0);
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            drive(vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].da);
            #1;
            chk($sformatf("v%0d fetch_gnt", i),   bus.Fetch_Gnt,   vecs[i].efg);
            chk($sformatf("v%0d dbg_gnt", i),     bus.Dbg_Gnt,     vecs[i].edg);
            chk($sformatf("v%0d mem_en", i),      bus.Mem_En,      vecs[i].een);
            chk($sformatf("v%0d mem_addr", i),    bus.Mem_Addr,    vecs[i].eaddr);
            chk($sformatf("v%0d fetch_valid", i), bus.Fetch_Valid, vecs[i].efv);
            chk($sformatf("v%0d fetch_data", i),  bus.Fetch_Data,  vecs[i].efd);
            chk($sformatf("v%0d dbg_valid", i),   bus.Dbg_Valid,   vecs[i].edv);
            chk($sformatf("v%0d dbg_data", i),    bus.Dbg_Data,    vecs[i].edd);
            chk($sformatf("v%0d dbg_err", i),     bus.Dbg_Err,     vecs[i].ede);
        end

        // Starvation: both requests held 12 cycles -> 8 fetch, 1 debug, fetch.
        for (int c = 0; c < 12; c++) begin
            logic exp_dbg;
            exp_dbg = (c == 8);
            @(negedge Clk);
            drive(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
            #1;
            chk($sformatf("starve c%0d fetch_gnt", c), bus.Fetch_Gnt, {31'd0, !exp_dbg});
            chk($sformatf("starve c%0d dbg_gnt", c),   bus.Dbg_Gnt,   {31'd0, exp_dbg});
            chk($sformatf("starve c%0d one_grant", c), bus.Fetch_Gnt & bus.Dbg_Gnt, 32'd0);
            chk($sformatf("starve c%0d mem_addr", c),  bus.Mem_Addr,
                exp_dbg ? 32'd128 : 32'd64);
            if (c == 1) chk("starve fetch_data", bus.Fetch_Data, mem_word(9'd64));
            if (c == 9) begin
                chk("starve dbg_valid", bus.Dbg_Valid, 32'd1);
                chk("starve dbg_data",  bus.Dbg_Data,  mem_word(9'd128));
                chk("starve fetch_valid_off", bus.Fetch_Valid, 32'd0);
            end
        end

        // Reset in the middle of the cycle after a fetch grant.
        @(negedge Clk);
        drive(1'b1, 32'h0000_0010, 1'b0, 32'd0);
        #1;
        chk("mid-rst grant", bus.Fetch_Gnt, 32'd1);
        @(negedge Clk);
        #1;
        chk("mid-rst pre valid", bus.Fetch_Valid, 32'd1);
        chk("mid-rst pre data",  bus.Fetch_Data,  32'h8C01_0004);
        #1;
        Rst = 1'b0;
        #1;
        chk("mid-rst fetch_valid", bus.Fetch_Valid, 32'd0);
        chk("mid-rst fetch_data",  bus.Fetch_Data,  32'd0);
        chk("mid-rst fetch_gnt",   bus.Fetch_Gnt,   32'd0);
        chk("mid-rst mem_en",      bus.Mem_En,      32'd0);
        chk("mid-rst dbg_data",    bus.Dbg_Data,    32'd0);
        chk("mid-rst dbg_err",     bus.Dbg_Err,     32'd0);
        chk("mid-rst dbg_valid",   bus.Dbg_Valid,   32'd0);
        @(negedge Clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            #1;
            chk($sformatf("post-rst c%0d fetch_valid", c), bus.Fetch_Valid, 32'd0);
            chk($sformatf("post-rst c%0d dbg_valid", c),   bus.Dbg_Valid,   32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning the instruction-memory word-index width (512 words).
REQ-002 The block SHALL have parameter STARVE_MAX, default 8, meaning the number of consecutive fetch grants allowed while a debug request waits.
REQ-003 The block SHALL have port Clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 The block SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port Fetch_Req  input  1  fetch stage requests an instruction read.
REQ-006 The block SHALL have port Fetch_Addr  input  32  byte address of the fetch read.
REQ-007 The block SHALL have port Fetch_Gnt  output  1  fetch request accepted this cycle.
REQ-008 The block SHALL have port Fetch_Valid  output  1  Fetch_Data holds the granted read result.
REQ-009 The block SHALL have port Fetch_Data  output  32  fetched instruction.
REQ-010 The block SHALL have port Dbg_Req  input  1  debug/readback port requests a read.
REQ-011 The block SHALL have port Dbg_Addr  input  32  byte address of the debug read.
REQ-012 The block SHALL have port Dbg_Gnt  output  1  debug request accepted this cycle.
REQ-013 The block SHALL have port Dbg_Valid  output  1  Dbg_Data and Dbg_Err are valid.
REQ-014 The block SHALL have port Dbg_Data  output  32  debug read result.
REQ-015 The block SHALL have port Dbg_Err  output  1  debug address misaligned or out of range.
REQ-016 The block SHALL have port Mem_En  output  1  synchronous memory read enable.
REQ-017 The block SHALL have port Mem_Addr  output  ADDR_W  word index to memory, Addr[ADDR_W+1:2].
REQ-018 The block SHALL have port Mem_Rdata  input  32  memory read data, valid one cycle after Mem_En.

Function
REQ-019 Grants SHALL be combinational from current requests and state; at most one of Fetch_Gnt, Dbg_Gnt SHALL be high per cycle.
REQ-020 Fetch SHALL have priority unless Dbg_Req is high and the starvation counter equals STARVE_MAX, in which case Dbg SHALL be granted.
REQ-021 The starvation counter SHALL increment (saturating at STARVE_MAX) on each fetch grant while Dbg_Req is high, and clear on any debug grant or on any cycle Dbg_Req is low.
REQ-022 Mem_En SHALL equal Fetch_Gnt OR Dbg_Gnt, with Mem_Addr taken from the granted requester; Mem_Addr SHALL be 0 when idle.
REQ-023 Read latency SHALL be exactly one cycle: a grant in cycle N SHALL yield a one-cycle Valid pulse to the same requester in cycle N+1 with Data = Mem_Rdata.
REQ-024 A one-hot owner FSM SHALL track the in-flight read: states IDLE, RD_FETCH, RD_DBG; next state = RD_FETCH on fetch grant, RD_DBG on debug grant, else IDLE.
REQ-025 Back-to-back grants SHALL sustain one read per cycle with no bubble, including fetch-to-debug and debug-to-fetch switches.
REQ-026 Address bits [1:0] SHALL be ignored for fetch; for debug, Addr[1:0] != 0 or Addr[31:ADDR_W+2] != 0 SHALL still be granted, but SHALL suppress Mem_En, return Dbg_Data = 0 and Dbg_Err = 1 with Dbg_Valid one cycle later.
REQ-027 Fetch address bits above ADDR_W+1 SHALL be dropped (wrap-around), no error reported.
REQ-028 Data outputs SHALL hold their last value when Valid is low.

Reset
REQ-029 On Rst low, FSM SHALL go to IDLE, starvation counter to 0, and Fetch_Valid, Dbg_Valid, Dbg_Err, Fetch_Data, Dbg_Data to 0, immediately and asynchronously.
REQ-030 Grants and Mem_En SHALL be forced low while Rst is low; an in-flight read at reset assertion SHALL be discarded with no Valid pulse after release.

Structure
REQ-031 State encodings, ADDR_W and STARVE_MAX defaults SHALL reside in the shared processor constants package.
REQ-032 The starvation counter SHALL be a sub-module named imem_starve_cnt; the remainder SHALL be flat.

Verification
REQ-033 Fetch_Req=1, Fetch_Addr=0x10, Mem_Rdata=0x8C010004 next cycle -> Fetch_Gnt=1, Mem_Addr=4, Fetch_Valid=1 and Fetch_Data=0x8C010004 one cycle later.
REQ-034 Fetch_Req and Dbg_Req held high 12 cycles -> 8 fetch grants, then 1 debug grant, then fetch resumes; never two grants in one cycle.
REQ-035 Dbg_Addr=0x6 -> Dbg_Gnt=1, Mem_En=0, next cycle Dbg_Valid=1, Dbg_Err=1, Dbg_Data=0.
REQ-036 Dbg_Addr=0x800 (ADDR_W=9) -> Dbg_Err=1; Fetch_Addr=0x804 -> Mem_Addr=1, no error.
REQ-037 Fetch grant in cycle N, Rst low mid-cycle N+1 -> all outputs 0 immediately, no Valid pulse after release.
REQ-038 Alternating fetch/debug grants on consecutive cycles -> Valid pulses route to the correct requester each cycle with matching data.
